// File: rtl/tcb_pkg.sv
// tcb_pkg: shared state and trigger-mode encodings for the trigger-capture engine
package tcb_pkg;
  typedef enum logic [2:0] {IDLE, RUN, POST, DONE, SEND} state_t;
  localparam logic [1:0] TM_LEVEL = 2'b00;
  localparam logic [1:0] TM_RISE  = 2'b01;
  localparam logic [1:0] TM_FALL  = 2'b10;
endpackage

// File: rtl/tcb_ring_ram.sv
// tcb_ring_ram: history buffer with one write port and one registered read port
module tcb_ring_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        q
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/trig_capture_buf.sv
// trig_capture_buf: ADC history capture with level/edge trigger and oldest-first streaming
module trig_capture_buf import tcb_pkg::*; #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int TIMER_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DATA_W-1:0]        trig_lvl,
  input  logic [1:0]               trig_mode,
  input  logic [$clog2(DEPTH)-1:0] post_cnt,
  output logic                     adc_req,
  input  logic                     adc_rdy,
  input  logic [DATA_W-1:0]        adc_data,
  output logic                     trd,
  output logic [TIMER_W-1:0]       trig_time,
  input  logic                     sbf,
  output logic                     sd_valid,
  output logic [DATA_W-1:0]        sd_data,
  output logic                     sd_last,
  input  logic                     sd_ready,
  output logic                     cd
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [AW-1:0] wr_ptr, rd_ptr, post_left, pcnt, raddr, oldest;
  logic [AW:0] fill, issued, loaded;
  logic [TIMER_W-1:0] timer;
  logic [DATA_W-1:0] lvl, prev, q;
  logic [1:0] mode;
  logic have_prev, q_vld, acc, hit, go, ren, load, fin;
  assign go = start && (state == IDLE || state == DONE);
  assign acc = adc_req && adc_rdy && !abort;
  assign fin = sd_valid && sd_ready && sd_last;
  assign load = q_vld && (!sd_valid || sd_ready);
  assign oldest = wr_ptr - fill[AW-1:0];
  // first read is issued on the DONE->SEND edge so a word is ready one cycle after entry
  assign ren = (state == DONE && state_n == SEND) || (state == SEND && issued != fill && (!q_vld || load));
  assign raddr = state == SEND ? rd_ptr : oldest;
  assign cd = state != SEND;
  always_comb
    hit = mode == TM_RISE ? have_prev && prev < lvl && adc_data >= lvl :
          mode == TM_FALL ? have_prev && prev >= lvl && adc_data < lvl :
          adc_data >= lvl;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (acc && hit) state_n = pcnt == '0 ? DONE : POST;
      POST: if (acc && post_left == AW'(1)) state_n = DONE;
      DONE: state_n = start ? RUN : sbf ? SEND : DONE;
      SEND: if (fin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_req <= 1'b0;
      trd <= 1'b0;
      trig_time <= '0;
      wr_ptr <= '0;
      fill <= '0;
      timer <= '0;
      post_left <= '0;
      have_prev <= 1'b0;
      prev <= '0;
      lvl <= '0;
      mode <= TM_LEVEL;
      pcnt <= '0;
      rd_ptr <= '0;
      issued <= '0;
      loaded <= '0;
      q_vld <= 1'b0;
      sd_valid <= 1'b0;
      sd_data <= '0;
      sd_last <= 1'b0;
    end else begin
      adc_req <= state_n == RUN || state_n == POST;
      trd <= state_n == DONE || state_n == SEND;
      if (go && !abort) begin
        wr_ptr <= '0;
        fill <= '0;
        timer <= '0;
        post_left <= '0;
        have_prev <= 1'b0;
        lvl <= trig_lvl;
        mode <= trig_mode;
        pcnt <= post_cnt;
      end else if (acc) begin
        wr_ptr <= wr_ptr + AW'(1);
        fill <= fill[AW] ? fill : fill + (AW+1)'(1);
        timer <= &timer ? timer : timer + TIMER_W'(1);
        prev <= adc_data;
        have_prev <= 1'b1;
        if (state == RUN && hit) begin
          trig_time <= timer;
          post_left <= pcnt;
        end else if (state == POST) post_left <= post_left - AW'(1);
      end
      if (abort) begin
        q_vld <= 1'b0;
        sd_valid <= 1'b0;
        sd_last <= 1'b0;
      end else begin
        if (ren) begin
          rd_ptr <= raddr + AW'(1);
          issued <= state == SEND ? issued + (AW+1)'(1) : (AW+1)'(1);
        end
        q_vld <= ren || (q_vld && !load);
        if (state == DONE) loaded <= '0;
        if (load) begin
          sd_valid <= 1'b1;
          sd_data <= q;
          sd_last <= loaded + (AW+1)'(1) == fill;
          loaded <= loaded + (AW+1)'(1);
        end else if (sd_valid && sd_ready) begin
          sd_valid <= 1'b0;
          sd_last <= 1'b0;
        end
      end
    end
  end
  tcb_ring_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(acc),
    .waddr(wr_ptr),
    .wdata(adc_data),
    .re(ren),
    .raddr(raddr),
    .q(q)
  );
endmodule

// File: tb/tb_trig_capture_buf.sv
// tb_trig_capture_buf: directed checks of capture, trigger modes, streaming, abort and reset
module tb_trig_capture_buf;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, adc_rdy = 1'b0, sbf = 1'b0, sd_ready = 1'b0;
  logic [7:0] trig_lvl = '0, adc_data = '0;
  logic [1:0] trig_mode = '0;
  logic [4:0] post_cnt = '0;
  logic adc_req, trd, sd_valid, sd_last, cd;
  logic [31:0] trig_time;
  logic [7:0] sd_data;
  int n_chk = 0, n_pass = 0, sidx = 0, nsmp = 0;
  bit will_acc = 1'b0;
  logic [7:0] smp [256];
  logic [7:0] exp_w [64];
  always #5 clk = ~clk;
  trig_capture_buf #(.DATA_W(8), .DEPTH(32), .TIMER_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trig_lvl(trig_lvl),
    .trig_mode(trig_mode), .post_cnt(post_cnt), .adc_req(adc_req), .adc_rdy(adc_rdy),
    .adc_data(adc_data), .trd(trd), .trig_time(trig_time), .sbf(sbf), .sd_valid(sd_valid),
    .sd_data(sd_data), .sd_last(sd_last), .sd_ready(sd_ready), .cd(cd)
  );
  initial forever begin
    @(posedge clk);
    if (will_acc) sidx++;
    #1;
    adc_rdy = adc_req && sidx < nsmp;
    adc_data = sidx < nsmp ? smp[sidx] : 8'h00;
    will_acc = adc_req && adc_rdy;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic arm(input logic [1:0] m, input logic [7:0] l, input logic [4:0] p);
    sidx = 0;
    trig_mode = m;
    trig_lvl = l;
    post_cnt = p;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic wait_trd(input string tag);
    int c = 0;
    while (!trd && c < 500) begin
      tick;
      c++;
    end
    chk({tag, " trd"}, trd, 1);
  endtask
  task automatic stream(input string tag, input int n, input bit bp);
    int got = 0, cyc = 0;
    logic [7:0] hold = '0;
    bit stalled = 1'b0;
    sbf = 1'b1;
    tick;
    sbf = 1'b0;
    chk({tag, " cd_send"}, cd, 0);
    chk({tag, " valid_entry"}, sd_valid, 0);
    while (got < n && cyc < 300) begin
      if (stalled) chk({tag, " hold"}, sd_data, hold);
      sd_ready = bp ? (cyc % 2 == 0) : 1'b1;
      if (sd_valid && sd_ready) begin
        chk({tag, " data"}, sd_data, exp_w[got]);
        chk({tag, " last"}, sd_last, got == n - 1);
        got++;
      end
      stalled = sd_valid && !sd_ready;
      hold = sd_data;
      tick;
      cyc++;
    end
    sd_ready = 1'b0;
    chk({tag, " count"}, got, n);
    if (!bp) chk({tag, " cycles"}, cyc, n + 1);
    chk({tag, " trd_end"}, trd, 0);
    chk({tag, " cd_end"}, cd, 1);
    chk({tag, " valid_end"}, sd_valid, 0);
  endtask
  initial begin
    tick;
    tick;
    chk("rst adc_req", adc_req, 0);
    chk("rst trd", trd, 0);
    chk("rst trig_time", trig_time, 0);
    chk("rst sd_valid", sd_valid, 0);
    chk("rst sd_data", sd_data, 0);
    chk("rst sd_last", sd_last, 0);
    chk("rst cd", cd, 1);
    rst = 1'b0;
    tick;
    // level trigger on a ramp with wrap-around
    for (int i = 0; i < 256; i++) smp[i] = 8'(i);
    nsmp = 256;
    arm(2'b00, 8'hD5, 5'd16);
    chk("lvl req_rise", adc_req, 1);
    wait_trd("lvl");
    chk("lvl trig_time", trig_time, 213);
    chk("lvl samples", sidx, 230);
    tick;
    chk("lvl no_extra", sidx, 230);
    chk("lvl req_done", adc_req, 0);
    for (int i = 0; i < 32; i++) exp_w[i] = 8'(198 + i);
    stream("lvl", 32, 1'b0);
    // rising crossing with sink backpressure
    smp[0] = 8'h90; smp[1] = 8'h90; smp[2] = 8'h10; smp[3] = 8'h85;
    for (int i = 4; i < 256; i++) smp[i] = 8'h00;
    arm(2'b01, 8'h80, 5'd0);
    wait_trd("rise");
    chk("rise trig_time", trig_time, 3);
    chk("rise samples", sidx, 4);
    exp_w[0] = 8'h90; exp_w[1] = 8'h90; exp_w[2] = 8'h10; exp_w[3] = 8'h85;
    stream("rise_bp", 4, 1'b1);
    // falling crossing after only five samples
    smp[0] = 8'h50; smp[1] = 8'h60; smp[2] = 8'h70; smp[3] = 8'h45; smp[4] = 8'h30;
    arm(2'b10, 8'h40, 5'd0);
    wait_trd("fall");
    chk("fall trig_time", trig_time, 4);
    chk("fall samples", sidx, 5);
    for (int i = 0; i < 5; i++) exp_w[i] = smp[i];
    stream("fall", 5, 1'b0);
    // abort in POST, then recapture with timer restarted
    for (int i = 0; i < 256; i++) smp[i] = 8'(i);
    arm(2'b00, 8'h05, 5'd10);
    for (int c = 0; sidx < 8 && c < 100; c++) tick;
    chk("abort in_post", adc_req, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort req", adc_req, 0);
    chk("abort trd", trd, 0);
    chk("abort cd", cd, 1);
    tick;
    tick;
    chk("abort idle", adc_req, 0);
    arm(2'b00, 8'h03, 5'd2);
    wait_trd("recap");
    chk("recap trig_time", trig_time, 3);
    chk("recap samples", sidx, 6);
    start = 1'b1;
    sbf = 1'b1;
    tick;
    start = 1'b0;
    sbf = 1'b0;
    chk("prio trd", trd, 0);
    chk("prio req", adc_req, 1);
    chk("prio cd", cd, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("prio abort", adc_req, 0);
    // asynchronous reset in the middle of a stream
    for (int i = 0; i < 256; i++) smp[i] = 8'(i + 1);
    arm(2'b00, 8'h03, 5'd3);
    wait_trd("rst");
    chk("rst trig_time_pre", trig_time, 2);
    sbf = 1'b1;
    tick;
    sbf = 1'b0;
    sd_ready = 1'b1;
    tick;
    tick;
    chk("rst mid_data", sd_data, 2);
    #1 rst = 1'b1;
    #1;
    chk("async adc_req", adc_req, 0);
    chk("async trd", trd, 0);
    chk("async trig_time", trig_time, 0);
    chk("async sd_valid", sd_valid, 0);
    chk("async sd_data", sd_data, 0);
    chk("async sd_last", sd_last, 0);
    chk("async cd", cd, 1);
    tick;
    rst = 1'b0;
    sd_ready = 1'b0;
    sbf = 1'b1;
    tick;
    sbf = 1'b0;
    chk("post_rst sbf_cd", cd, 1);
    chk("post_rst trd", trd, 0);
    tick;
    chk("post_rst valid", sd_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/trig_capture_buf.md
# trig_capture_buf

Parametrised trigger-capture engine for the sampled-ADC acquisition path. It requests samples from the ADC over a req/rdy handshake and stores them in a circular history buffer. On a programmable level or edge trigger it records the trigger timestamp and captures a programmable number of post-trigger samples. On request it streams the buffer, oldest first, over a valid/ready serial-data port.

## Interface
- DATA_W, 8, sample width
- DEPTH, 32, buffer entries; power of two, ≥4
- TIMER_W, 32, sample-timestamp width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  arm capture (honoured in IDLE and DONE)
- abort  in  1  return to IDLE from any state
- trig_lvl  in  DATA_W  trigger threshold, unsigned
- trig_mode  in  2  00 level (≥), 01 rising crossing, 10 falling crossing, 11 reserved = level
- post_cnt  in  $clog2(DEPTH)  post-trigger samples after the trigger sample
- adc_req  out  1  sample request
- adc_rdy  in  1  sample valid
- adc_data  in  DATA_W  sample
- trd  out  1  capture complete, buffer holds data
- trig_time  out  TIMER_W  index of trigger sample
- sbf  in  1  send-buffer request
- sd_valid  out  1  stream word valid
- sd_data  out  DATA_W  stream word
- sd_last  out  1  final stream word
- sd_ready  in  1  sink accepts
- cd  out  1  high when not streaming

## Operation
- States: IDLE, RUN, POST, DONE, SEND.
- IDLE → RUN on start. Clears wr_ptr, fill, timer, post counter, and trd. Latches trig_lvl, trig_mode, and post_cnt.
- A sample is accepted on a cycle where adc_req && adc_rdy. Each accepted sample is:
  - written at wr_ptr;
  - wr_ptr increments modulo DEPTH;
  - fill increments, saturating at DEPTH;
  - timer increments, saturating at all-ones.
- Trigger is evaluated only on accepted samples in RUN:
  - level: data ≥ lvl;
  - rising: prev < lvl && data ≥ lvl;
  - falling: prev ≥ lvl && data < lvl.
- prev is the previous accepted sample. Edge modes cannot fire on the first sample after start.
- On trigger, the sample is stored and trig_time ← timer value before increment (first sample = 0). Then:
  - if post_cnt = 0: go to DONE;
  - otherwise: go to POST.
- POST accepts post_cnt further samples, then goes to DONE.
- DONE: trd = 1, adc_req = 0.
  - sbf → SEND.
  - start → RUN, discarding the buffer; start has priority over sbf.
- SEND streams fill words. The first word is at index (wr_ptr − fill) mod DEPTH, i.e. oldest first.
- sd_last is asserted with the final word. After the final handshake: trd ← 0, go to IDLE.
- sbf outside DONE, and start in RUN/POST/SEND, are ignored.
- abort in any state → IDLE: trd ← 0, adc_req ← 0, sd_valid ← 0. Buffer contents are not cleared.

## Timing
- Reset values:
  - state IDLE;
  - adc_req 0, trd 0, trig_time 0;
  - sd_valid 0, sd_data 0, sd_last 0;
  - cd 1.
- adc_req is registered. It is 1 in RUN/POST and 0 elsewhere, and rises the cycle after start. Accepted samples may arrive back-to-back, one per cycle.
- Trigger decision is in the accept cycle. State is POST/DONE in the following cycle; trig_time is valid from that same cycle.
- The DONE transition happens the cycle after the last accepted post sample. trd is high in that cycle and adc_req is already 0, so no extra sample is accepted.
- SEND:
  - sd_valid is asserted the cycle after entry; cd is 0 during SEND.
  - sd_data and sd_last hold stable while sd_valid && !sd_ready.
  - After a handshake, the next word is presented the next cycle. Throughput is 1 word/cycle.
- Buffer read is synchronous, 1-cycle latency; prefetch so the throughput above holds.
- Wrap-around: after more than DEPTH samples, the oldest entries are overwritten and fill stays at DEPTH.
- Reset mid-capture or mid-stream takes effect immediately. The state is lost.

## Structure
- Package tcb_pkg:
  - state enum;
  - trig_mode encodings TM_LEVEL, TM_RISE, TM_FALL.
- Sub-module tcb_ring_ram: DEPTH × DATA_W, one write port and one registered read port.
- Pointers, fill, timer, and the FSM live in the top module.

## Test plan
- Level mode, lvl = 0xD5, DEPTH = 32, post_cnt = 16, ramp 0,1,2… with rdy every cycle.
  - trig_time = 213;
  - trd rises after sample 229;
  - streamed data = 198…229, 32 words, sd_last on 229.
- Rising mode, lvl = 0x80.
  - Stream 0x90,0x90,0x10,0x85: trigger fires on the 4th sample and trig_time = 3.
  - The first 0x90 does not fire.
- Falling mode, post_cnt = 0, only 5 samples before trigger.
  - fill = 5;
  - SEND emits exactly 5 words in order, sd_last on the 5th.
- Sink backpressure: sd_ready toggles 1010…
  - No word is lost or duplicated; sd_data is stable while stalled.
- Mid-POST: abort, then start.
  - abort: adc_req falls next cycle, state IDLE, trd 0.
  - Subsequent start re-captures correctly with timer restarted at 0.
- rst asserted mid-SEND.
  - All outputs return to reset values immediately.
  - sbf after reset is ignored until a new capture completes.
